// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder cell plus a registered carry, LSB first.
// Optional signed-overflow flag is built only when SERIAL_ADDER_OVERFLOW_EN is defined.

module structuralFullAdder (
  input  logic a,
  input  logic b,
  input  logic carryin,
  output logic sum,
  output logic carryout
);
  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (sum, ab_x, carryin);
  and g_a0 (ab_a, a, b);
  and g_a1 (cx_a, ab_x, carryin);
  or  g_o0 (carryout, ab_a, cx_a);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  structuralFullAdder u_fa (
    .a        (a_q[0]),
    .b        (b_q[0]),
    .carryin  (carry_q),
    .sum      (fa_sum),
    .carryout (fa_cout)
  );

  assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = carryin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // carry_q during the last bit is the carry into the MSB.
  always_comb begin
    ovf_d = ovf_q;
    if (last_bit) ovf_d = carry_q ^ fa_cout;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign carryout = cout_q;
endmodule
